// File: rtl/umi_packet_split.sv
// -----------------------------------------------------------------------------
// umi_packet_split
//
// Narrowing stage for UMI packets. A packet arriving on the wide input bus
// (IDW bits of data) is re-emitted as a sequence of packets that each fit the
// narrow output bus (ODW bits). Destination and source addresses advance by
// one chunk (ODW/8 bytes) per beat. Only data-carrying opcodes (write,
// write_posted, rdma, read_resp) are split; every other opcode, and any packet
// that already fits in one chunk, passes through as a single unchanged beat.
//
// Ports:
//   clk, nreset            clock, asynchronous active-low reset
//   umi_in_valid/ready     input handshake
//   umi_in_cmd             input command (opcode/size/len/eom/... fields)
//   umi_in_dstaddr/srcaddr input addresses
//   umi_in_data            input data, byte 0 in bits [7:0]
//   umi_out_valid/ready    output handshake (valid holds until ready)
//   umi_out_cmd            output command, len/eom rewritten per chunk
//   umi_out_dstaddr/srcaddr per-chunk addresses
//   umi_out_data           per-chunk data
//
// Build option:
//   UMI_SPLIT_DATA_MASK_EN  when defined, output bytes beyond the chunk's
//                           byte count are forced to zero. Cycle behaviour
//                           is the same with or without it.
//
// Command field positions used here:
//   [4:0] opcode, [7:5] size, [15:8] len, [22] eom; everything else is
//   copied verbatim.
// -----------------------------------------------------------------------------
module umi_packet_split #(
    parameter int CW  = 32,
    parameter int AW  = 64,
    parameter int IDW = 256,
    parameter int ODW = 64
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           umi_in_valid,
    input  logic [CW-1:0]  umi_in_cmd,
    input  logic [AW-1:0]  umi_in_dstaddr,
    input  logic [AW-1:0]  umi_in_srcaddr,
    input  logic [IDW-1:0] umi_in_data,
    output logic           umi_in_ready,
    output logic           umi_out_valid,
    output logic [CW-1:0]  umi_out_cmd,
    output logic [AW-1:0]  umi_out_dstaddr,
    output logic [AW-1:0]  umi_out_srcaddr,
    output logic [ODW-1:0] umi_out_data,
    input  logic           umi_out_ready
);

    localparam int              CHUNK   = ODW / 8;
    localparam logic [16:0]     CHUNK_B = 17'(CHUNK);
    localparam logic [AW-1:0]   CHUNK_A = AW'(CHUNK);

`ifdef UMI_SPLIT_DATA_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    // Opcodes that carry a data payload and therefore may be split.
    function automatic logic is_data_op(input logic [4:0] op);
        logic r;
        case (op)
            5'h03:   r = 1'b1;   // write
            5'h05:   r = 1'b1;   // write_posted
            5'h07:   r = 1'b1;   // rdma
            5'h02:   r = 1'b1;   // read response
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Bytes carried by the chunk that starts with `rem` bytes outstanding.
    function automatic logic [16:0] min_chunk(input logic [16:0] rem);
        logic [16:0] r;
        if (rem > CHUNK_B) begin
            r = CHUNK_B;
        end else begin
            r = rem;
        end
        return r;
    endfunction

    // Command for one chunk of a split packet: len shrinks to the chunk,
    // eom survives only on the final chunk.
    function automatic logic [CW-1:0] beat_cmd(input logic [CW-1:0] cmd,
                                               input logic [16:0] rem);
        logic [CW-1:0] c;
        logic [16:0]   cb;
        c = cmd;
        cb = min_chunk(rem);
        c[15:8] = 8'((cb >> cmd[7:5]) - 17'd1);
        if (rem <= CHUNK_B) begin
            c[22] = cmd[22];
        end else begin
            c[22] = 1'b0;
        end
        return c;
    endfunction

    // Zero bytes at index >= cb when masking is built in; identity otherwise.
    function automatic logic [ODW-1:0] mask_data(input logic [ODW-1:0] d,
                                                 input logic [16:0] cb);
        logic [ODW-1:0] m;
        m = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (!MASK_EN || (17'(i) < cb)) begin
                m[i*8 +: 8] = 8'hFF;
            end else begin
                m[i*8 +: 8] = 8'h00;
            end
        end
        return d & m;
    endfunction

    state_t           state_r;
    logic [1:0]       rst_done_r;
    logic             out_valid_r;
    logic [CW-1:0]    out_cmd_r;
    logic [AW-1:0]    out_dst_r;
    logic [AW-1:0]    out_src_r;
    logic [ODW-1:0]   out_data_r;
    // Working copy describing the next chunk still to be presented.
    logic [CW-1:0]    cmd_r;
    logic [16:0]      rem_r;
    logic [AW-1:0]    dst_r;
    logic [AW-1:0]    src_r;
    logic [IDW-1:0]   data_r;

    logic [2:0]       in_size_s;
    logic [16:0]      in_bytes_s;
    logic [16:0]      in_cb_s;
    logic             in_data_op_s;
    logic             in_illegal_s;
    logic             split_s;
    logic             in_ready_s;
    logic             accept_s;

    assign in_size_s    = umi_in_cmd[7:5];
    // (len+1) << size is exact in 17 bits: at most 256 * 128.
    assign in_bytes_s   = ({9'd0, umi_in_cmd[15:8]} + 17'd1) << in_size_s;
    assign in_cb_s      = min_chunk(in_bytes_s);
    assign in_data_op_s = is_data_op(umi_in_cmd[4:0]);
    // A word wider than the output chunk cannot be split; it goes out as one
    // truncated beat.
    assign in_illegal_s = in_data_op_s & ((17'd1 << in_size_s) > CHUNK_B);
    assign split_s      = in_data_op_s & ~in_illegal_s & (in_bytes_s > CHUNK_B);

    // Ready only in IDLE with the output slot free or draining this cycle,
    // which lets a new packet enter on the same edge the last beat leaves.
    assign in_ready_s = rst_done_r[1] & (state_r == ST_IDLE) &
                        (~out_valid_r | umi_out_ready);
    assign accept_s   = umi_in_valid & in_ready_s;

    // Splitter state machine: output beat registers plus working chunk state.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r     <= ST_IDLE;
            rst_done_r  <= 2'b00;
            out_valid_r <= 1'b0;
            out_cmd_r   <= '0;
            out_dst_r   <= '0;
            out_src_r   <= '0;
            out_data_r  <= '0;
            cmd_r       <= '0;
            rem_r       <= 17'd0;
            dst_r       <= '0;
            src_r       <= '0;
            data_r      <= '0;
        end else begin
            rst_done_r <= {rst_done_r[0], 1'b1};
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        out_valid_r <= 1'b1;
                        if (split_s) begin
                            out_cmd_r <= beat_cmd(umi_in_cmd, in_bytes_s);
                            state_r   <= ST_SPLIT;
                        end else begin
                            out_cmd_r <= umi_in_cmd;
                            state_r   <= ST_IDLE;
                        end
                        out_dst_r  <= umi_in_dstaddr;
                        out_src_r  <= umi_in_srcaddr;
                        out_data_r <= mask_data(umi_in_data[ODW-1:0], in_cb_s);
                        // Pre-advance to the second chunk; ignored unless split.
                        cmd_r  <= umi_in_cmd;
                        rem_r  <= in_bytes_s - CHUNK_B;
                        dst_r  <= umi_in_dstaddr + CHUNK_A;
                        src_r  <= umi_in_srcaddr + CHUNK_A;
                        data_r <= umi_in_data >> ODW;
                    end else if (umi_out_ready) begin
                        out_valid_r <= 1'b0;
                    end else begin
                        out_valid_r <= out_valid_r;
                    end
                end
                ST_SPLIT: begin
                    if (umi_out_ready) begin
                        out_cmd_r  <= beat_cmd(cmd_r, rem_r);
                        out_dst_r  <= dst_r;
                        out_src_r  <= src_r;
                        out_data_r <= mask_data(data_r[ODW-1:0], min_chunk(rem_r));
                        rem_r      <= rem_r - CHUNK_B;
                        dst_r      <= dst_r + CHUNK_A;
                        src_r      <= src_r + CHUNK_A;
                        data_r     <= data_r >> ODW;
                        // Leave SPLIT as the final chunk is loaded so the
                        // next packet can be accepted when it commits.
                        if (rem_r <= CHUNK_B) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_SPLIT;
                        end
                    end else begin
                        state_r <= ST_SPLIT;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign umi_in_ready    = in_ready_s;
    assign umi_out_valid   = out_valid_r;
    assign umi_out_cmd     = out_cmd_r;
    assign umi_out_dstaddr = out_dst_r;
    assign umi_out_srcaddr = out_src_r;
    assign umi_out_data    = out_data_r;

    umi_packet_split_chk u_chk (
        .clk     (clk),
        .nreset  (nreset),
        .accept  (accept_s),
        .illegal (in_illegal_s)
    );

endmodule

// -----------------------------------------------------------------------------
// umi_packet_split_chk
//
// Simulation checks for umi_packet_split.
// Ports: clk, nreset, accept (input handshake fired), illegal (accepted
// packet has a word size wider than one output chunk).
// -----------------------------------------------------------------------------
module umi_packet_split_chk (
    input  logic clk,
    input  logic nreset,
    input  logic accept,
    input  logic illegal
);

    // Flag split-opcode packets whose word size exceeds the output chunk.
    always_ff @(posedge clk) begin
        if (nreset) begin
            assert (!(accept && illegal))
                else $error("umi_packet_split: word size wider than output chunk");
        end
    end

endmodule

// File: tb/tb_umi_packet_split.sv
// -----------------------------------------------------------------------------
// tb_umi_packet_split
//
// Directed bench for umi_packet_split at default parameters. A table of
// packets with hand-computed per-beat expectations is applied in a loop,
// followed by hand-written sequences for reset release, back-to-back
// packets, output back-pressure and reset in the middle of a packet.
// -----------------------------------------------------------------------------
module tb_umi_packet_split;

    localparam int CW  = 32;
    localparam int AW  = 64;
    localparam int IDW = 256;
    localparam int ODW = 64;

    localparam logic [IDW-1:0] DPAT =
        256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [63:0] D0 = 64'h0706050403020100;
    localparam logic [63:0] D1 = 64'h0f0e0d0c0b0a0908;
    localparam logic [63:0] D2 = 64'h1716151413121110;
    localparam logic [63:0] D3 = 64'h1f1e1d1c1b1a1918;
`ifdef UMI_SPLIT_DATA_MASK_EN
    localparam logic [63:0] D2H = 64'h0000000013121110;
`else
    localparam logic [63:0] D2H = 64'h1716151413121110;
`endif

    logic           clk;
    logic           nreset;
    logic           umi_in_valid;
    logic [CW-1:0]  umi_in_cmd;
    logic [AW-1:0]  umi_in_dstaddr;
    logic [AW-1:0]  umi_in_srcaddr;
    logic [IDW-1:0] umi_in_data;
    logic           umi_in_ready;
    logic           umi_out_valid;
    logic [CW-1:0]  umi_out_cmd;
    logic [AW-1:0]  umi_out_dstaddr;
    logic [AW-1:0]  umi_out_srcaddr;
    logic [ODW-1:0] umi_out_data;
    logic           umi_out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    umi_packet_split #(.CW(CW), .AW(AW), .IDW(IDW), .ODW(ODW)) dut (
        .clk             (clk),
        .nreset          (nreset),
        .umi_in_valid    (umi_in_valid),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_in_ready    (umi_in_ready),
        .umi_out_valid   (umi_out_valid),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .umi_out_ready   (umi_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]       cmd;
        logic [63:0]       dst;
        logic [63:0]       src;
        logic [2:0]        nb;
        logic [3:0][31:0]  ecmd;
        logic [3:0][63:0]  edst;
        logic [3:0][63:0]  esrc;
        logic [3:0][63:0]  edat;
    } vec_t;

    vec_t vecs [6];

    // Command with fixed non-zero upper fields so copying is observable.
    function automatic logic [31:0] mk_cmd(input logic [4:0] op, input logic [2:0] size,
                                           input logic [7:0] len, input logic eom);
        return {9'h14B, eom, 2'b01, 4'hA, len, size, op};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_pkt(input logic [31:0] cmd, input logic [63:0] dst,
                             input logic [63:0] src);
        umi_in_valid   = 1'b1;
        umi_in_cmd     = cmd;
        umi_in_dstaddr = dst;
        umi_in_srcaddr = src;
        umi_in_data    = DPAT;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        drive_pkt(v.cmd, v.dst, v.src);
        #1;
        check($sformatf("v%0d_in_ready", idx), 64'(umi_in_ready), 64'd1);
        @(posedge clk);
        #1 umi_in_valid = 1'b0;
        for (int b = 0; b < 32'(v.nb); b++) begin
            @(negedge clk);
            check($sformatf("v%0d_b%0d_valid", idx, b), 64'(umi_out_valid), 64'd1);
            check($sformatf("v%0d_b%0d_cmd", idx, b), 64'(umi_out_cmd), 64'(v.ecmd[b]));
            check($sformatf("v%0d_b%0d_dst", idx, b), umi_out_dstaddr, v.edst[b]);
            check($sformatf("v%0d_b%0d_src", idx, b), umi_out_srcaddr, v.esrc[b]);
            check($sformatf("v%0d_b%0d_data", idx, b), umi_out_data, v.edat[b]);
            if (b == 32'(v.nb) - 1) begin
                check($sformatf("v%0d_last_in_ready", idx), 64'(umi_in_ready), 64'd1);
            end
        end
        @(negedge clk);
        check($sformatf("v%0d_idle_after", idx), 64'(umi_out_valid), 64'd0);
    endtask

    logic [63:0] st_dst [6];
    logic [63:0] st_dat [6];
    logic        st_rdy [6];
    logic        st_ir  [6];
    logic        hit;

    initial begin
        // write_posted size0 len31: four 8-byte beats, eom on the last only
        vecs[0].cmd  = mk_cmd(5'h05, 3'd0, 8'd31, 1'b1);
        vecs[0].dst  = 64'h1000;
        vecs[0].src  = 64'h2000;
        vecs[0].nb   = 3'd4;
        vecs[0].ecmd = {mk_cmd(5'h05, 3'd0, 8'd7, 1'b1), mk_cmd(5'h05, 3'd0, 8'd7, 1'b0),
                        mk_cmd(5'h05, 3'd0, 8'd7, 1'b0), mk_cmd(5'h05, 3'd0, 8'd7, 1'b0)};
        vecs[0].edst = {64'h1018, 64'h1010, 64'h1008, 64'h1000};
        vecs[0].esrc = {64'h2018, 64'h2010, 64'h2008, 64'h2000};
        vecs[0].edat = {D3, D2, D1, D0};
        // read_resp size2 len4 = 20 bytes: 8, 8, 4
        vecs[1].cmd  = mk_cmd(5'h02, 3'd2, 8'd4, 1'b1);
        vecs[1].dst  = 64'h3000;
        vecs[1].src  = 64'h4000;
        vecs[1].nb   = 3'd3;
        vecs[1].ecmd = {32'h0, mk_cmd(5'h02, 3'd2, 8'd0, 1'b1),
                        mk_cmd(5'h02, 3'd2, 8'd1, 1'b0), mk_cmd(5'h02, 3'd2, 8'd1, 1'b0)};
        vecs[1].edst = {64'h0, 64'h3010, 64'h3008, 64'h3000};
        vecs[1].esrc = {64'h0, 64'h4010, 64'h4008, 64'h4000};
        vecs[1].edat = {64'h0, D2H, D1, D0};
        // read request: no data, passes through unchanged
        vecs[2].cmd  = mk_cmd(5'h01, 3'd3, 8'd15, 1'b1);
        vecs[2].dst  = 64'h5000;
        vecs[2].src  = 64'h6000;
        vecs[2].nb   = 3'd1;
        vecs[2].ecmd = {32'h0, 32'h0, 32'h0, mk_cmd(5'h01, 3'd3, 8'd15, 1'b1)};
        vecs[2].edst = {64'h0, 64'h0, 64'h0, 64'h5000};
        vecs[2].esrc = {64'h0, 64'h0, 64'h0, 64'h6000};
        vecs[2].edat = {64'h0, 64'h0, 64'h0, D0};
        // write 16 bytes with destination wrapping past 2^64
        vecs[3].cmd  = mk_cmd(5'h03, 3'd3, 8'd1, 1'b1);
        vecs[3].dst  = 64'hFFFF_FFFF_FFFF_FFF8;
        vecs[3].src  = 64'h7000;
        vecs[3].nb   = 3'd2;
        vecs[3].ecmd = {32'h0, 32'h0, mk_cmd(5'h03, 3'd3, 8'd0, 1'b1),
                        mk_cmd(5'h03, 3'd3, 8'd0, 1'b0)};
        vecs[3].edst = {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8};
        vecs[3].esrc = {64'h0, 64'h0, 64'h7008, 64'h7000};
        vecs[3].edat = {64'h0, 64'h0, D1, D0};
        // write of exactly one chunk: not split, cmd unchanged
        vecs[4].cmd  = mk_cmd(5'h03, 3'd3, 8'd0, 1'b1);
        vecs[4].dst  = 64'h8000;
        vecs[4].src  = 64'h9000;
        vecs[4].nb   = 3'd1;
        vecs[4].ecmd = {32'h0, 32'h0, 32'h0, mk_cmd(5'h03, 3'd3, 8'd0, 1'b1)};
        vecs[4].edst = {64'h0, 64'h0, 64'h0, 64'h8000};
        vecs[4].esrc = {64'h0, 64'h0, 64'h0, 64'h9000};
        vecs[4].edat = {64'h0, 64'h0, 64'h0, D0};
        // rdma size1 len15 = 32 bytes, eom=0 stays 0 on every beat
        vecs[5].cmd  = mk_cmd(5'h07, 3'd1, 8'd15, 1'b0);
        vecs[5].dst  = 64'hA000;
        vecs[5].src  = 64'hB000;
        vecs[5].nb   = 3'd4;
        vecs[5].ecmd = {mk_cmd(5'h07, 3'd1, 8'd3, 1'b0), mk_cmd(5'h07, 3'd1, 8'd3, 1'b0),
                        mk_cmd(5'h07, 3'd1, 8'd3, 1'b0), mk_cmd(5'h07, 3'd1, 8'd3, 1'b0)};
        vecs[5].edst = {64'hA018, 64'hA010, 64'hA008, 64'hA000};
        vecs[5].esrc = {64'hB018, 64'hB010, 64'hB008, 64'hB000};
        vecs[5].edat = {D3, D2, D1, D0};

        nreset         = 1'b0;
        umi_in_valid   = 1'b0;
        umi_in_cmd     = '0;
        umi_in_dstaddr = '0;
        umi_in_srcaddr = '0;
        umi_in_data    = '0;
        umi_out_ready  = 1'b1;

        // Reset state and reset_done release timing
        #2;
        check("rst_out_valid", 64'(umi_out_valid), 64'd0);
        check("rst_in_ready", 64'(umi_in_ready), 64'd0);
        check("rst_out_cmd", 64'(umi_out_cmd), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #1 nreset = 1'b1;
        @(negedge clk);
        check("rel_in_ready_1", 64'(umi_in_ready), 64'd0);
        @(negedge clk);
        check("rel_in_ready_2", 64'(umi_in_ready), 64'd1);

        // Table-driven packets
        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-to-back 32-byte writes: 8 beats in 8 cycles
        @(negedge clk);
        drive_pkt(mk_cmd(5'h03, 3'd3, 8'd3, 1'b1), 64'h1000, 64'h2000);
        @(posedge clk);
        #1 drive_pkt(mk_cmd(5'h03, 3'd3, 8'd3, 1'b1), 64'h2000, 64'h3000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("b2b_%0d_valid", i), 64'(umi_out_valid), 64'd1);
            check($sformatf("b2b_%0d_dst", i), umi_out_dstaddr,
                  (i < 4) ? 64'h1000 + 64'(8 * i) : 64'h2000 + 64'(8 * (i - 4)));
            check($sformatf("b2b_%0d_eom", i), 64'(umi_out_cmd[22]),
                  ((i % 4) == 3) ? 64'd1 : 64'd0);
            hit = umi_in_valid & umi_in_ready;
            if (i == 3) begin
                check("b2b_accept_at_last", 64'(hit), 64'd1);
            end
            @(posedge clk);
            #1;
            if (hit) begin
                umi_in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_idle_after", 64'(umi_out_valid), 64'd0);

        // Output back-pressure mid-packet
        st_dst = '{64'hC000, 64'hC008, 64'hC008, 64'hC008, 64'hC010, 64'hC018};
        st_dat = '{D0, D1, D1, D1, D2, D3};
        st_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        st_ir  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        drive_pkt(mk_cmd(5'h03, 3'd3, 8'd3, 1'b1), 64'hC000, 64'hD000);
        @(posedge clk);
        #1 umi_in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            umi_out_ready = st_rdy[i];
            #1;
            check($sformatf("stall_%0d_valid", i), 64'(umi_out_valid), 64'd1);
            check($sformatf("stall_%0d_dst", i), umi_out_dstaddr, st_dst[i]);
            check($sformatf("stall_%0d_data", i), umi_out_data, st_dat[i]);
            check($sformatf("stall_%0d_in_ready", i), 64'(umi_in_ready), 64'(st_ir[i]));
        end
        @(negedge clk);
        check("stall_idle_after", 64'(umi_out_valid), 64'd0);

        // Reset asserted while beat 2 of 4 is presented
        @(negedge clk);
        drive_pkt(mk_cmd(5'h03, 3'd3, 8'd3, 1'b1), 64'hE000, 64'hF000);
        @(posedge clk);
        #1 umi_in_valid = 1'b0;
        @(negedge clk);
        check("mid_b0_dst", umi_out_dstaddr, 64'hE000);
        @(negedge clk);
        check("mid_b1_dst", umi_out_dstaddr, 64'hE008);
        #1 nreset = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(umi_out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(umi_in_ready), 64'd0);
        @(negedge clk);
        #1 nreset = 1'b1;
        @(negedge clk);
        check("mid_rel1_in_ready", 64'(umi_in_ready), 64'd0);
        check("mid_rel1_out_valid", 64'(umi_out_valid), 64'd0);
        @(negedge clk);
        check("mid_rel2_in_ready", 64'(umi_in_ready), 64'd1);
        check("mid_rel2_out_valid", 64'(umi_out_valid), 64'd0);
        @(negedge clk);
        check("mid_rel3_out_valid", 64'(umi_out_valid), 64'd0);

        // Normal traffic after the mid-packet reset
        run_vec(40, vecs[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
